// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite encodings for the command master: response codes and
// protection-field bit constants.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT   = 3'b000;
  localparam logic [2:0] PROT_PRIV      = 3'b001;
  localparam logic [2:0] PROT_NONSECURE = 3'b010;
  localparam logic [2:0] PROT_INSTR     = 3'b100;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4_lite_order_fifo.sv
// One-bit synchronous FIFO remembering the type (read/write) of every issued
// transaction so responses can be taken back strictly in issue order.
module axi4_lite_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[PW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_dout  = r_mem[r_rd_ptr[PW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/axi4_lite_cmd_master.sv
// AXI4-Lite master engine: one valid/ready command stream in, AXI4-Lite
// channels out, responses returned in command-issue order.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SW  = DW / 8,
  parameter int OUT = 4
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_prot,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [SW-1:0] cmd_wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_resp,
  output logic          busy,
  output logic [AW-1:0] AWADDR,
  output logic [2:0]    AWPROT,
  output logic          AWVALID,
  input  logic          AWREADY,
  output logic [DW-1:0] WDATA,
  output logic [SW-1:0] WSTRB,
  output logic          WVALID,
  input  logic          WREADY,
  input  logic [1:0]    BRESP,
  input  logic          BVALID,
  output logic          BREADY,
  output logic [AW-1:0] ARADDR,
  output logic [2:0]    ARPROT,
  output logic          ARVALID,
  input  logic          ARREADY,
  input  logic [DW-1:0] RDATA,
  input  logic [1:0]    RRESP,
  input  logic          RVALID,
  output logic          RREADY
);

  // Handshake rule on every channel: a beat transfers on a rising clock edge
  // where VALID and READY are both high; VALID never drops and its payload
  // never changes until that edge.

  logic          r_arvalid;
  logic [AW-1:0] r_araddr;
  logic [2:0]    r_arprot;
  logic          r_awvalid;
  logic [AW-1:0] r_awaddr;
  logic [2:0]    r_awprot;
  logic          r_wvalid;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_rsp_valid;
  logic          r_rsp_we;
  logic [DW-1:0] r_rsp_rdata;
  logic [1:0]    r_rsp_resp;

  logic w_full;
  logic w_empty;
  logic w_head_we;
  logic w_ar_free;
  logic w_aw_free;
  logic w_w_free;
  logic w_cmd_ready;
  logic w_accept;
  logic w_rsp_free;
  logic w_rready;
  logic w_bready;
  logic w_r_cap;
  logic w_b_cap;

  assign w_ar_free   = !r_arvalid || ARREADY;
  assign w_aw_free   = !r_awvalid || AWREADY;
  assign w_w_free    = !r_wvalid  || WREADY;
  assign w_cmd_ready = !ARESET && !w_full && w_ar_free && w_aw_free && w_w_free;
  assign w_accept    = cmd_valid && w_cmd_ready;

  // Only the channel matching the oldest outstanding type may deliver a beat.
  assign w_rsp_free = !r_rsp_valid || rsp_ready;
  assign w_rready   = !ARESET && !w_empty && !w_head_we && w_rsp_free;
  assign w_bready   = !ARESET && !w_empty &&  w_head_we && w_rsp_free;
  assign w_r_cap    = RVALID && w_rready;
  assign w_b_cap    = BVALID && w_bready;

  axi4_lite_order_fifo #(
    .DEPTH (OUT)
  ) u_order_fifo (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_push  (w_accept),
    .i_din   (cmd_we),
    .i_pop   (w_r_cap || w_b_cap),
    .o_dout  (w_head_we),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arprot  <= PROT_DEFAULT;
    end else if (w_accept && !cmd_we) begin
      r_arvalid <= 1'b1;
      r_araddr  <= cmd_addr;
      r_arprot  <= cmd_prot;
    end else if (ARREADY) begin
      r_arvalid <= 1'b0;
    end
  end

  // AW and W are launched together but retire independently.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_awprot  <= PROT_DEFAULT;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '1;
    end else if (w_accept && cmd_we) begin
      r_awvalid <= 1'b1;
      r_awaddr  <= cmd_addr;
      r_awprot  <= cmd_prot;
      r_wvalid  <= 1'b1;
      r_wdata   <= cmd_wdata;
      r_wstrb   <= cmd_wstrb;
    end else begin
      if (AWREADY) begin
        r_awvalid <= 1'b0;
      end
      if (WREADY) begin
        r_wvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else if (w_r_cap) begin
      r_rsp_valid <= 1'b1;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= RDATA;
      r_rsp_resp  <= RRESP;
    end else if (w_b_cap) begin
      r_rsp_valid <= 1'b1;
      r_rsp_we    <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= BRESP;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign ARVALID   = r_arvalid;
  assign ARADDR    = r_araddr;
  assign ARPROT    = r_arprot;
  assign AWVALID   = r_awvalid;
  assign AWADDR    = r_awaddr;
  assign AWPROT    = r_awprot;
  assign WVALID    = r_wvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign RREADY    = w_rready;
  assign BREADY    = w_bready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign busy      = !w_empty || r_rsp_valid || r_arvalid || r_awvalid || r_wvalid;

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Bench for axi4_lite_cmd_master: behavioural AXI4-Lite slave with random
// READY/VALID timing, issue-order response model, directed scenario tasks.
`timescale 1ns/1ps
module tb_axi4_lite_cmd_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int OUT = 4;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_prot;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  axi4_lite_cmd_master #(.AW(AW), .DW(DW), .SW(SW), .OUT(OUT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_b_hs = 0;
  int ar_pct = 100, aw_pct = 100, w_pct = 100, r_pct = 100, b_pct = 100, rsp_pct = 100;

  logic [34:0] exp_q[$];     // {we, rdata, resp} in issue order
  logic [34:0] exp_ar_q[$];  // {addr, prot}
  logic [34:0] exp_aw_q[$];  // {addr, prot}
  logic [35:0] exp_w_q[$];   // {data, strb}
  logic [31:0] slv_r_q[$];   // read addresses awaiting an R beat
  logic [31:0] slv_aw_q[$];  // write addresses awaiting their W beat
  logic [31:0] slv_b_q[$];   // completed writes awaiting a B beat
  int          slv_w_cnt = 0;
  bit          r_fire = 0, b_fire = 0, prev_cap = 0;
  logic [31:0] rdata_ovr[logic [31:0]];

  // Slave behaviour: read data is a hash of the address, response codes come
  // from address bits so random traffic exercises all four encodings.
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (rdata_ovr.exists(a)) return rdata_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic pick(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // ---------------- slave driver (negedge + 1) ----------------
  always @(negedge ACLK) begin
    #1;
    if (ARESET) begin
      ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0; rsp_ready = 0;
      r_fire = 0; b_fire = 0;
    end else begin
      ARREADY   = pick(ar_pct);
      AWREADY   = pick(aw_pct);
      WREADY    = pick(w_pct);
      rsp_ready = pick(rsp_pct);
      if (r_fire) RVALID = 1'b0;
      r_fire = 0;
      if (!RVALID && slv_r_q.size() != 0 && pick(r_pct)) begin
        RVALID = 1'b1;
        RDATA  = rdata_of(slv_r_q[0]);
        RRESP  = slv_r_q[0][5:4];
      end
      if (b_fire) BVALID = 1'b0;
      b_fire = 0;
      if (!BVALID && slv_b_q.size() != 0 && pick(b_pct)) begin
        BVALID = 1'b1;
        BRESP  = slv_b_q[0][7:6];
      end
    end
  end

  // ---------------- monitor / scoreboard (negedge + 2) ----------------
  always @(negedge ACLK) begin
    logic [34:0] e;
    logic [35:0] ew;
    #2;
    if (ARESET) begin
      exp_q.delete(); exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
      slv_r_q.delete(); slv_aw_q.delete(); slv_b_q.delete();
      slv_w_cnt = 0; prev_cap = 0;
    end else begin
      if (prev_cap) begin
        n_vec++;
        if (rsp_valid !== 1'b1) begin
          n_err++; $display("FAIL rsp_latency: rsp_valid=%b required 1", rsp_valid);
        end
      end
      prev_cap = (RVALID && RREADY) || (BVALID && BREADY);
      if (rsp_valid && rsp_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rsp_unexpected: got we=%b data=%h resp=%b, none expected",
                            rsp_we, rsp_rdata, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_we, rsp_rdata, rsp_resp} !== e) begin
            n_err++; $display("FAIL rsp_data: got we=%b data=%h resp=%b required we=%b data=%h resp=%b",
                              rsp_we, rsp_rdata, rsp_resp, e[34], e[33:2], e[1:0]);
          end
        end
      end
      if (ARVALID && ARREADY) begin
        n_vec++;
        e = (exp_ar_q.size() != 0) ? exp_ar_q.pop_front() : 35'bx;
        if ({ARADDR, ARPROT} !== e) begin
          n_err++; $display("FAIL ar_beat: got %h/%b required %h/%b", ARADDR, ARPROT, e[34:3], e[2:0]);
        end
        slv_r_q.push_back(ARADDR);
      end
      if (AWVALID && AWREADY) begin
        n_vec++;
        e = (exp_aw_q.size() != 0) ? exp_aw_q.pop_front() : 35'bx;
        if ({AWADDR, AWPROT} !== e) begin
          n_err++; $display("FAIL aw_beat: got %h/%b required %h/%b", AWADDR, AWPROT, e[34:3], e[2:0]);
        end
        slv_aw_q.push_back(AWADDR);
      end
      if (WVALID && WREADY) begin
        n_vec++;
        ew = (exp_w_q.size() != 0) ? exp_w_q.pop_front() : 36'bx;
        if ({WDATA, WSTRB} !== ew) begin
          n_err++; $display("FAIL w_beat: got %h/%h required %h/%h", WDATA, WSTRB, ew[35:4], ew[3:0]);
        end
        slv_w_cnt++;
      end
      while (slv_aw_q.size() != 0 && slv_w_cnt > 0) begin
        slv_b_q.push_back(slv_aw_q.pop_front());
        slv_w_cnt--;
      end
      if (RVALID && RREADY) begin r_fire = 1; slv_r_q.delete(0); end
      if (BVALID && BREADY) begin b_fire = 1; slv_b_q.delete(0); n_b_hs++; end
      if (cmd_valid && cmd_ready) begin
        if (cmd_we) begin
          exp_q.push_back({1'b1, 32'h0, cmd_addr[7:6]});
          exp_aw_q.push_back({cmd_addr, cmd_prot});
          exp_w_q.push_back({cmd_wdata, cmd_wstrb});
        end else begin
          exp_q.push_back({1'b0, rdata_of(cmd_addr), cmd_addr[5:4]});
          exp_ar_q.push_back({cmd_addr, cmd_prot});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] p,
                       input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_prot = p; cmd_wdata = d; cmd_wstrb = s;
    #3;
    while (!cmd_ready && n < 200) begin @(negedge ACLK); #3; n++; end
    if (!cmd_ready) begin
      n_vec++; n_err++; $display("FAIL cmd_timeout: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic cmd_idle();
    @(negedge ACLK);
    cmd_valid = 1'b0;
    #3;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin @(negedge ACLK); #3; n++; end
    if (!rsp_valid) begin
      n_vec++; n_err++; $display("FAIL %s_rsp_timeout: rsp_valid=%b required 1", name, rsp_valid);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge ACLK); #3; n++; end
    n_vec++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s_drain: pending=%0d busy=%b required 0/0", name, exp_q.size(), busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ARESET = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h44; cmd_prot = 3'b0;
    cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
    repeat (3) @(negedge ACLK);
    #3;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    @(negedge ACLK);
    ARESET = 1'b0; cmd_valid = 1'b0;
    #3;
    n_vec++;
    if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid, busy} !== 7'b0) begin
      n_err++; $display("FAIL reset_valids: got %b required 0000000",
                        {ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid, busy});
    end
    n_vec++;
    if ({ARADDR, AWADDR, WDATA, WSTRB} !== {32'h0, 32'h0, 32'h0, 4'hF}) begin
      n_err++; $display("FAIL reset_payload: got %h %h %h %h required 0 0 0 f", ARADDR, AWADDR, WDATA, WSTRB);
    end
    n_vec++;
    if ({rsp_we, rsp_rdata, rsp_resp} !== 35'h0) begin
      n_err++; $display("FAIL reset_rsp: got %b/%h/%b required 0", rsp_we, rsp_rdata, rsp_resp);
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    issue(1'b1, 32'h10, 3'b000, 32'hDEAD_BEEF, 4'hF);
    cmd_idle();
    n_vec++;
    if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB} !== {2'b11, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
      n_err++; $display("FAIL wr_launch: got %b%b %h %h %h required 11 10 deadbeef f",
                        AWVALID, WVALID, AWADDR, WDATA, WSTRB);
    end
    @(negedge ACLK); #3;
    n_vec++;
    if ({AWVALID, WVALID} !== 2'b00) begin
      n_err++; $display("FAIL wr_one_cycle: got %b%b required 00", AWVALID, WVALID);
    end
    wait_rsp("wr");
    n_vec++;
    if ({rsp_we, rsp_rdata, rsp_resp} !== {1'b1, 32'h0, 2'b00}) begin
      n_err++; $display("FAIL wr_rsp: got %b/%h/%b required 1/0/00", rsp_we, rsp_rdata, rsp_resp);
    end
    drain("wr");
  endtask

  task automatic test_read_slverr();
    rdata_ovr[32'h20] = 32'h1234_5678;
    r_pct = 0;
    issue(1'b0, 32'h20, 3'b010, 32'h0, 4'h0);
    cmd_idle();
    repeat (5) begin @(negedge ACLK); #3; end
    r_pct = 100;
    wait_rsp("rd");
    n_vec++;
    if ({rsp_we, rsp_rdata, rsp_resp} !== {1'b0, 32'h1234_5678, 2'b10}) begin
      n_err++; $display("FAIL rd_slverr: got %b/%h/%b required 0/12345678/10", rsp_we, rsp_rdata, rsp_resp);
    end
    drain("rd");
  endtask

  task automatic test_full();
    int acc = 0, first_cap = -1, first_rdy = -1;
    logic [31:0] a = $urandom;
    r_pct = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_prot = 3'b001;
      #3;
      if (cmd_ready) begin acc++; a = $urandom; end
    end
    n_vec++;
    if (acc != OUT || cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL full_accepts: got %0d ready=%b required %0d ready=0", acc, cmd_ready, OUT);
    end
    r_pct = 100;
    for (int i = 0; i < 40 && acc < 6; i++) begin
      @(negedge ACLK);
      cmd_addr = a;
      #3;
      if (first_cap < 0 && RVALID && RREADY) first_cap = i;
      if (cmd_ready) begin
        if (first_rdy < 0) first_rdy = i;
        acc++; a = $urandom;
      end
    end
    cmd_idle();
    n_vec++;
    if (first_cap < 0 || first_rdy != first_cap + 1 || acc != 6) begin
      n_err++; $display("FAIL full_reopen: ready at %0d cap at %0d acc %0d required cap+1 and 6",
                        first_rdy, first_cap, acc);
    end
    drain("full");
  endtask

  task automatic test_r_before_b();
    b_pct = 0;
    issue(1'b1, 32'h100, 3'b000, 32'hA5A5_0001, 4'h3);
    issue(1'b0, 32'h204, 3'b000, 32'h0, 4'h0);
    cmd_idle();
    repeat (6) begin @(negedge ACLK); #3; end
    n_vec++;
    if ({RVALID, RREADY, rsp_valid} !== 3'b100) begin
      n_err++; $display("FAIL r_stall: got rvalid/rready/rsp_valid %b%b%b required 100", RVALID, RREADY, rsp_valid);
    end
    b_pct = 100;
    wait_rsp("rb");
    n_vec++;
    if (rsp_we !== 1'b1) begin n_err++; $display("FAIL rb_order: first rsp_we=%b required 1", rsp_we); end
    drain("rb");
  endtask

  task automatic test_w_delay();
    int nb;
    logic [31:0] d = $urandom;
    w_pct = 0;
    nb = n_b_hs;
    issue(1'b1, 32'h40, 3'b100, d, 4'h5);
    cmd_idle();
    n_vec++;
    if ({AWVALID, WVALID} !== 2'b11) begin n_err++; $display("FAIL wd_launch: got %b%b required 11", AWVALID, WVALID); end
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK); #3;
      n_vec++;
      if ({AWVALID, WVALID, cmd_ready, WDATA} !== {3'b010, d}) begin
        n_err++; $display("FAIL wd_hold: got aw/w/rdy %b%b%b data %h required 010 %h",
                          AWVALID, WVALID, cmd_ready, WDATA, d);
      end
    end
    w_pct = 100;
    drain("wd");
    n_vec++;
    if (n_b_hs - nb != 1) begin n_err++; $display("FAIL wd_single_b: got %0d B beats required 1", n_b_hs - nb); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rsp_pct = 0;
    issue(1'b0, 32'h300, 3'b000, 32'h0, 4'h0);
    issue(1'b0, 32'h304, 3'b000, 32'h0, 4'h0);
    issue(1'b0, 32'h308, 3'b000, 32'h0, 4'h0);
    cmd_idle();
    repeat (6) begin @(negedge ACLK); #3; end
    n_vec++;
    if ({rsp_valid, busy, RVALID, RREADY} !== 4'b1110) begin
      n_err++; $display("FAIL mid_pre: got rsp_valid/busy/rvalid/rready %b%b%b%b required 1110",
                        rsp_valid, busy, RVALID, RREADY);
    end
    @(negedge ACLK);
    ARESET = 1'b1;
    #3;
    n_vec++;
    if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b required 0", cmd_ready); end
    @(negedge ACLK);
    ARESET = 1'b0; rsp_pct = 100;
    #3;
    n_vec++;
    if ({ARVALID, AWVALID, WVALID, rsp_valid, busy, RREADY, BREADY, WSTRB} !== {7'b0, 4'hF}) begin
      n_err++; $display("FAIL mid_cleared: got %b%b%b%b%b%b%b strb %h required 0000000 f",
                        ARVALID, AWVALID, WVALID, rsp_valid, busy, RREADY, BREADY, WSTRB);
    end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 6; blk++) begin
      ar_pct  = int'($urandom_range(100, 20));
      aw_pct  = int'($urandom_range(100, 20));
      w_pct   = int'($urandom_range(100, 20));
      r_pct   = int'($urandom_range(100, 20));
      b_pct   = int'($urandom_range(100, 20));
      rsp_pct = int'($urandom_range(100, 20));
      for (int k = 0; k < 25; k++) begin
        issue(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC, 3'($urandom_range(7, 0)),
              $urandom, 4'($urandom_range(15, 0)));
        if ($urandom_range(3, 0) == 0) cmd_idle();
      end
      cmd_idle();
    end
    ar_pct = 100; aw_pct = 100; w_pct = 100; r_pct = 100; b_pct = 100; rsp_pct = 100;
    drain("rand");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0; rsp_ready = 0;
    RDATA = '0; RRESP = '0; BRESP = '0;
    test_reset();
    test_single_write();
    test_read_slverr();
    test_full();
    test_r_before_b();
    test_w_delay();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

Synthesizable AXI4-Lite master engine that turns a single valid/ready command stream (read or write) into AXI4-Lite channel transactions. Up to OUT transactions may be outstanding; responses return on one valid/ready stream in command-issue order. It sits between on-chip sequencers or register-access logic and the system AXI4-Lite interconnect, replacing testbench-only master models in synthesizable designs.

## Interface
- AW, 32, address width
- DW, 32, data width
- SW, DW/8, strobe width
- OUT, 4, max outstanding transactions; power of 2, ≥2
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous active-high (one clock; reset is synchronous and active-high)
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  AW  address; cmd_prot  in  3  protection
- cmd_wdata  in  DW; cmd_wstrb  in  SW  write data/strobe (ignored on reads)
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_we  out  1  response type; rsp_rdata  out  DW  (0 for writes); rsp_resp  out  2  RRESP/BRESP
- busy  out  1  any transaction outstanding or response held
- AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master ports, widths per AW/DW/SW

## Operation
- Order FIFO (depth OUT, 1 bit = we) pushed on command accept, popped on response capture; occupancy = outstanding count.
- cmd_ready = !ofifo_full & ar_free & aw_free & w_free; x_free = !xVALID | xREADY.
- Read accept: ARVALID<=1, ARADDR/ARPROT loaded. Write accept: AWVALID<=1 and WVALID<=1 together, AW/W payload loaded. Each VALID clears independently on its own READY; payload held stable while VALID.
- AW and W may complete in either order or same cycle; no dependence on B.
- Response capture: RREADY = !ofifo_empty & !head_we & (!rsp_valid | rsp_ready); BREADY same with head_we. R/B beat captured into rsp register on handshake, rsp_valid<=1; cleared on rsp_ready when no new capture.
- R arriving while head is a write (or vice versa) is stalled, not dropped — responses strictly issue-ordered.
- SLVERR/DECERR passed through unchanged; no retry.
- busy = !ofifo_empty | rsp_valid | ARVALID | AWVALID | WVALID.

## Timing
- Reset values: all VALIDs 0, RREADY/BREADY 0, addr/prot/WDATA 0, WSTRB all-ones, rsp_valid 0, rsp_* 0, cmd_ready 0 during ARESET, FIFO empty.
- Command accept at edge N → xVALID high from N+1.
- Response latency: R/B handshake at edge M → rsp_valid high from M+1; full throughput one response/cycle while rsp_ready=1.
- Back-to-back commands: one per cycle while slave READY stays high and FIFO not full.
- Full: OUT outstanding → cmd_ready=0; a same-cycle response pop does not raise cmd_ready that cycle (push gated on registered full).
- Reset mid-operation: outstanding transactions discarded, all state cleared in one cycle; interconnect/slave must be reset concurrently.

## Structure
- Package axi4_lite_pkg: resp encodings (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11), prot field constants.
- Sub-module axi4_lite_order_fifo: parametrised depth-OUT, 1-bit sync FIFO with full/empty, pointer wrap via extra MSB.

## Test plan
- Single write 0x10←0xDEADBEEF, strb 0xF, slave READY immediate → AW/W valid one cycle, rsp_we=1, rsp_resp=OKAY one cycle after B.
- Read 0x20, slave returns 0x12345678/SLVERR after 5 cycles → rsp_rdata=0x12345678, rsp_resp=2'b10.
- OUT=4: issue 6 reads, slave withholds R → exactly 4 ARs accepted, cmd_ready low until first R captured.
- Write then read; slave presents R before B → RREADY held 0 until B captured; responses emerge write then read.
- WREADY 3 cycles after AWREADY → AWVALID drops first, WVALID held with stable data, single B accepted.
- ARESET asserted with 2 outstanding and rsp_valid high → next cycle all VALIDs 0, busy 0, WSTRB all-ones.
